// File: rtl/fl_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// fl_alloc_ctrl_if : dispatch/retire/flush bundle between the pipeline and the
//                    free-list allocation controller
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fl_alloc_ctrl_if;
  logic [1:0]  id_req_num;
  logic [1:0]  rob_retire_num;
  logic        rob_mispredict;
  logic [1:0]  id_dispatch_num;
  logic        id_stall;
  logic        fl_recover;
  logic [6:0]  fl_count;
  logic        fl_err;
  logic [15:0] stall_cycles;

  modport master (
    output id_req_num, rob_retire_num, rob_mispredict,
    input  id_dispatch_num, id_stall, fl_recover, fl_count, fl_err, stall_cycles
  );

  modport slave (
    input  id_req_num, rob_retire_num, rob_mispredict,
    output id_dispatch_num, id_stall, fl_recover, fl_count, fl_err, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/fl_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// fl_alloc_ctrl : free-register allocation controller (grant, stall, flush)
// Optional macro FL_RETIRE_BYPASS_EN forwards same-cycle retires to dispatch.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fl_alloc_ctrl #(
  parameter int FREE_REGS = 64  // must stay below 126 so the 8-bit sum sign bit is meaningful
) (
  input wire              clock,
  input wire              reset,
  fl_alloc_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [6:0] c_free  = 7'(FREE_REGS);
  localparam logic [7:0] c_free8 = {1'b0, c_free};

  state_t      r_state;
  state_t      w_state_next;
  logic [6:0]  r_count;
  logic [6:0]  w_count_next;
  logic        r_err;
  logic        w_err_next;
  logic [15:0] r_stall_cycles;

  logic [1:0]  w_req;
  logic [1:0]  w_ret;
  logic [1:0]  w_grant;
  logic [7:0]  w_avail;
  logic [7:0]  w_sum;
  logic        w_stall;

  // Request/retire encodings of 3 behave as 2.
  assign w_req = (bus.id_req_num     == 2'd3) ? 2'd2 : bus.id_req_num;
  assign w_ret = (bus.rob_retire_num == 2'd3) ? 2'd2 : bus.rob_retire_num;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= RUN;
      r_count        <= c_free;
      r_err          <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_err_next   = r_err;
    w_grant      = 2'd0;
    w_sum        = 8'd0;
`ifdef FL_RETIRE_BYPASS_EN
    w_avail      = {1'b0, r_count} + {6'd0, w_ret};
`else
    w_avail      = {1'b0, r_count};
`endif

    case (r_state)
      RUN: begin
        if (bus.rob_mispredict) begin
          // Mispredict cycle drops its own request and retire; FLUSH restores the count.
          w_state_next = FLUSH;
        end else begin
          w_grant = (w_avail >= {6'd0, w_req}) ? w_req : w_avail[1:0];
          w_sum   = {1'b0, r_count} - {6'd0, w_grant} + {6'd0, w_ret};
          if (w_sum[7]) begin
            w_count_next = 7'd0;
            w_err_next   = 1'b1;
          end else if (w_sum > c_free8) begin
            w_count_next = c_free;
            w_err_next   = 1'b1;
          end else begin
            w_count_next = w_sum[6:0];
          end
        end
      end
      FLUSH: begin
        w_count_next = c_free;
        w_state_next = bus.rob_mispredict ? FLUSH : RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase

    if (!reset) begin
      w_grant = 2'd0;
    end
  end

  assign w_stall             = reset && (w_grant < w_req);

  assign bus.id_dispatch_num = w_grant;
  assign bus.id_stall        = w_stall;
  assign bus.fl_recover      = (r_state == FLUSH);
  assign bus.fl_count        = r_count;
  assign bus.fl_err          = r_err;
  assign bus.stall_cycles    = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_fl_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fl_alloc_ctrl : randomized scoreboard bench for fl_alloc_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fl_alloc_ctrl;

  localparam int c_free = 64;

  typedef struct {
    bit          known;
    logic [1:0]  grant;
    logic        stall;
    logic        recover;
    logic [6:0]  count;
    logic        err;
    logic [15:0] stalls;
  } exp_t;

  logic clock;
  logic reset;
  fl_alloc_ctrl_if bus ();

  fl_alloc_ctrl #(.FREE_REGS(c_free)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: plain integer bookkeeping of the free pool.
  bit m_known    = 0;
  int m_count    = 0;
  bit m_flushing = 0;
  bit m_err      = 0;
  int m_stalls   = 0;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(bit rst, int req, int ret, bit misp);
    exp_t e;
    int r, t, avail, g, n;
    @(negedge clock);
    reset              = rst;
    bus.id_req_num     = 2'(req);
    bus.rob_retire_num = 2'(ret);
    bus.rob_mispredict = misp;

    r = min2(req, 2);
    t = min2(ret, 2);
    if (!rst || m_flushing || misp) begin
      g = 0;
    end else begin
`ifdef FL_RETIRE_BYPASS_EN
      avail = m_count + t;
`else
      avail = m_count;
`endif
      g = min2(r, avail);
    end
    e.known   = m_known;
    e.grant   = 2'(g);
    e.stall   = rst && (g < r);
    e.recover = m_flushing;
    e.count   = 7'(m_count);
    e.err     = m_err;
    e.stalls  = 16'(m_stalls);
    q.push_back(e);

    if (!rst) begin
      m_known = 1; m_count = c_free; m_flushing = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (e.stall) m_stalls = min2(m_stalls + 1, 65535);
      if (m_flushing) begin
        m_count    = c_free;
        m_flushing = misp;
      end else if (misp) begin
        m_flushing = 1;
      end else begin
        n = m_count - g + t;
        if (n > c_free) begin m_count = c_free; m_err = 1; end
        else if (n < 0) begin m_count = 0;  m_err = 1; end
        else m_count = n;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs just before posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dispatch_num", 16'(bus.id_dispatch_num), 16'(e.grant));
        chk("id_stall",     16'(bus.id_stall),        16'(e.stall));
        if (e.known) begin
          chk("fl_recover",   16'(bus.fl_recover), 16'(e.recover));
          chk("fl_count",     16'(bus.fl_count),   16'(e.count));
          chk("fl_err",       16'(bus.fl_err),     16'(e.err));
          chk("stall_cycles", bus.stall_cycles,    e.stalls);
        end
      end
    end
  end

  initial begin
    int budget;
    reset              = 1'b0;
    bus.id_req_num     = 2'd0;
    bus.rob_retire_num = 2'd0;
    bus.rob_mispredict = 1'b0;

    cycle(0, 2, 2, 1);
    cycle(0, 3, 0, 0);
    // Drain the pool two at a time, then retire into an empty pool.
    for (int i = 0; i < 32; i++) cycle(1, 2, 0, 0);
    cycle(1, 2, 2, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 2, 0, 0);
    cycle(1, 3, 3, 0);
    // Mispredict with a request pending, then back-to-back mispredicts in FLUSH.
    cycle(1, 2, 1, 1);
    cycle(1, 2, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 2, 2, 1);
    cycle(1, 2, 2, 1);
    cycle(1, 2, 0, 0);
    // Reset during FLUSH.
    cycle(1, 0, 0, 1);
    cycle(0, 2, 1, 1);
    cycle(1, 0, 0, 0);
    // Overflow at full pool, sticky until reset.
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 63) != 0,
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
            $urandom_range(0, 15) == 0);
    end

    // Long stall run to reach the stall counter ceiling.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 65600; i++) cycle(1, 2, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 2, 0, 0);
    cycle(1, 2, 0, 0);

    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    @(negedge clock);
    #6;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
